// File: rtl/mmp_iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmp_iddmm_pkg
// Description : Shared types and constants for the IDDMM Montgomery
//               multiplier final-subtraction responder.
//               - state_t : FSM state encoding for mmp_iddmm_sub
//               - c_WD    : default word width (bits)
//               - c_N     : default words per operand
//               - c_AW    : default word address width
// Revision    : 1.0 - initial release
// ============================================================================
package mmp_iddmm_pkg;

    localparam int c_WD = 128;
    localparam int c_N  = 32;
    localparam int c_AW = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SDRAIN = 3'd2,
        DECIDE = 3'd3,
        OUT    = 3'd4,
        ODRAIN = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mmp_iddmm_sub_dly.sv
`default_nettype none
// ============================================================================
// Module      : mmp_iddmm_sub_dly
// Description : RD_LAT-deep register delay line. Carries the read tag
//               {valid, last, addr} alongside the RAM read so the tag lines
//               up with the returned data word.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset (clears all stages)
//               d_i  - tag entering the line (same cycle as rd_ena)
//               q_o  - tag leaving the line (same cycle as read data)
// Revision    : 1.0 - initial release
// ============================================================================
module mmp_iddmm_sub_dly #(
    parameter int RD_LAT = 1,
    parameter int W      = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [RD_LAT];

    genvar g;
    generate
        for (g = 0; g < RD_LAT; g++) begin : g_stage
            if (g == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) pipe_q[0] <= '0;
                    else     pipe_q[0] <= d_i;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) pipe_q[g] <= '0;
                    else     pipe_q[g] <= pipe_q[g-1];
                end
            end
        end
    endgenerate

    assign q_o = pipe_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mmp_iddmm_sub.sv
`default_nettype none
// ============================================================================
// Module      : mmp_iddmm_sub
// Description : Final conditional subtraction for the IDDMM Montgomery
//               multiplier. On a comp_req rising edge it scans A and M to
//               find whether {an, A} >= M, then streams A-M or A word by
//               word and pulses comp_end.
// Ports       : clk, rst (async, active high)
//               comp_req/comp_end - request level / one-cycle done pulse
//               an                - top carry of the result, sampled at start
//               rd_ena/rd_addr    - shared read port for the A and M RAMs
//               a_rdata/m_rdata   - RAM data, RD_LAT cycles after rd_ena
//               res_valid/addr/data/last - result word stream
//               busy              - high from start through the comp_end cycle
// Config      : MMP_SUB_SKIP_EN - when defined, a no-subtract decision goes
//               straight to DONE (A is already the result in RAM). Default
//               build always runs the output pass (constant time).
// Revision    : 1.0 - initial release
// ============================================================================
module mmp_iddmm_sub
    import mmp_iddmm_pkg::*;
#(
    parameter int WD     = c_WD,
    parameter int N      = c_N,
    parameter int AW     = c_AW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          comp_req,
    output logic          comp_end,
    input  logic          an,
    output logic          rd_ena,
    output logic [AW-1:0] rd_addr,
    input  logic [WD-1:0] a_rdata,
    input  logic [WD-1:0] m_rdata,
    output logic          res_valid,
    output logic [AW-1:0] res_addr,
    output logic [WD-1:0] res_data,
    output logic          res_last,
    output logic          busy
);

    localparam logic [AW-1:0] c_LAST  = AW'(N - 1);
    localparam logic [2:0]    c_DRAIN = 3'(RD_LAT - 1);
    localparam int            c_TW    = AW + 2;

    state_t        state_q;
    logic          comp_req_q;
    logic          an_q;
    logic          borrow_q;
    logic          sel_sub_q;
    logic          rd_ena_q;
    logic [AW-1:0] rd_addr_q;
    logic [2:0]    drain_q;
    logic          comp_end_q;
    logic          busy_q;

    logic [c_TW-1:0] w_tag_in;
    logic [c_TW-1:0] w_tag_out;
    logic            w_ret_valid;
    logic            w_ret_last;
    logic [AW-1:0]   w_ret_addr;
    logic [WD:0]     w_diff;
    logic            w_sel;
    logic            w_out_pass;

    assign w_tag_in = {rd_ena_q, (rd_addr_q == c_LAST), rd_addr_q};

    mmp_iddmm_sub_dly #(
        .RD_LAT (RD_LAT),
        .W      (c_TW)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i (w_tag_in),
        .q_o (w_tag_out)
    );

    assign {w_ret_valid, w_ret_last, w_ret_addr} = w_tag_out;

    // One word of the borrow chain, evaluated on each returned word pair.
    assign w_diff = {1'b0, a_rdata} - {1'b0, m_rdata} - {{WD{1'b0}}, borrow_q};

    // {an, A} >= M when the top carry is set or the scan left no borrow.
    assign w_sel = an_q | ~borrow_q;

    // Words returning during OUT/ODRAIN belong to the output pass; scan-pass
    // returns always land in SCAN/SDRAIN.
    assign w_out_pass = (state_q == OUT) || (state_q == ODRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            comp_req_q <= 1'b0;
            an_q       <= 1'b0;
            borrow_q   <= 1'b0;
            sel_sub_q  <= 1'b0;
            rd_ena_q   <= 1'b0;
            rd_addr_q  <= '0;
            drain_q    <= '0;
            comp_end_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            comp_req_q <= comp_req;
            comp_end_q <= 1'b0;
            if (w_ret_valid) borrow_q <= w_diff[WD];
            case (state_q)
                IDLE: begin
                    if (comp_req && !comp_req_q) begin
                        an_q      <= an;
                        borrow_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        rd_ena_q  <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (rd_addr_q == c_LAST) begin
                        rd_ena_q <= 1'b0;
                        drain_q  <= '0;
                        state_q  <= SDRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                SDRAIN: begin
                    if (drain_q == c_DRAIN) state_q <= DECIDE;
                    else                    drain_q <= drain_q + 3'd1;
                end
                DECIDE: begin
                    sel_sub_q <= w_sel;
                    borrow_q  <= 1'b0;
`ifdef MMP_SUB_SKIP_EN
                    if (!w_sel) begin
                        comp_end_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        rd_ena_q  <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= OUT;
                    end
`else
                    rd_ena_q  <= 1'b1;
                    rd_addr_q <= '0;
                    state_q   <= OUT;
`endif
                end
                OUT: begin
                    if (rd_addr_q == c_LAST) begin
                        rd_ena_q <= 1'b0;
                        drain_q  <= '0;
                        state_q  <= ODRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                ODRAIN: begin
                    if (drain_q == c_DRAIN) begin
                        comp_end_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign comp_end  = comp_end_q;
    assign busy      = busy_q;
    assign rd_ena    = rd_ena_q;
    assign rd_addr   = rd_addr_q;

    // Result stream is aligned to the returned word and forced to zero
    // whenever no word is presented.
    assign res_valid = w_ret_valid & w_out_pass;
    assign res_addr  = res_valid ? w_ret_addr : '0;
    assign res_last  = res_valid & w_ret_last;
    assign res_data  = !res_valid ? '0 : (sel_sub_q ? w_diff[WD-1:0] : a_rdata);

endmodule
`default_nettype wire

// File: doc/mmp_iddmm_sub.md
Name: mmp_iddmm_sub

Overview:
- Final conditional-subtraction responder for the IDDMM Montgomery multiplier: the far end of the comp_req/comp_end handshake raised by the PE controller after the last carry is saved to an.
- Reads the N-word Montgomery result A and the N-word modulus M from the word RAMs.
- Decides whether {an, A} >= M, then streams out either A-M or A word by word, and pulses comp_end.

Parameters:
- WD, 128, word width in bits
- N, 32, words per operand
- AW, 5, word address width (2^AW >= N)
- RD_LAT, 1, RAM read latency in cycles (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- comp_req  in  1  level request from controller; held high until comp_end is seen
- comp_end  out  1  one-cycle done pulse
- an  in  1  top carry bit of the result (ref_an); sampled at start
- rd_ena  out  1  RAM read strobe for the A and M RAMs
- rd_addr  out  AW  word address for the A and M reads (shared)
- a_rdata  in  WD  A word, valid RD_LAT cycles after rd_ena
- m_rdata  in  WD  M word, valid RD_LAT cycles after rd_ena
- res_valid  out  1  result word strobe
- res_addr  out  AW  result word index
- res_data  out  WD  result word
- res_last  out  1  high with the final result word (index N-1)
- busy  out  1  high from start until the comp_end cycle inclusive

Behaviour:
- Reset values: all outputs 0; state IDLE; borrow 0; sel_sub 0; internal pipeline valids 0.
- Start condition: in IDLE, a comp_req rising edge (comp_req=1 and the registered comp_req_d=0).
  - On start: latch an into an_r and clear borrow.
  - A comp_req that stays high after DONE does not restart the block.
- States:
  - IDLE -> SCAN on start.
  - SCAN: issues rd_ena for addr 0..N-1, one per cycle, with no gaps; -> SDRAIN after addr N-1 is issued.
  - SDRAIN: waits RD_LAT cycles for the returned words; -> DECIDE.
  - DECIDE (1 cycle): sel_sub = an_r | ~borrow; clear borrow; -> OUT.
  - OUT: re-reads addr 0..N-1, one per cycle; -> ODRAIN after addr N-1.
  - ODRAIN: waits RD_LAT cycles; -> DONE.
  - DONE: comp_end=1 for one cycle; busy drops the cycle after; -> IDLE.
- Borrow chain: diff = a_rdata - m_rdata - borrow, computed at WD+1 bits; borrow_next = diff[WD]. The chain runs on returned words in ascending address order.
  - Scan pass: only the borrow is kept; no result output.
  - Output pass: res_data = sel_sub ? diff[WD-1:0] : a_rdata.
  - res_valid and res_addr are aligned to the returned word, i.e. issue address delayed by RD_LAT.
- Latency, start to comp_end: 2N + 2*RD_LAT + 2 cycles. For N=32, RD_LAT=1 this is 68 cycles.
- Boundary cases:
  - A == M exactly: borrow = 0, so the result is all-zero words.
  - an_r = 1: always subtract, whatever the borrow; the wrap-around of the dropped top bit is intended.
  - comp_req falling mid-operation: ignored; the operation completes.
  - Reset mid-operation: back to IDLE at once; res_valid and comp_end go low immediately; no partial comp_end is issued.
- rd_addr holds its last value when rd_ena=0.

Optional Feature:
- Macro: MMP_SUB_SKIP_EN.
- Defined: if sel_sub=0 in DECIDE, go directly to DONE. The result is already in the A RAM, so no res_valid is issued.
  - Latency in that case: N + RD_LAT + 2 cycles.
- Undefined (default, constant-time): the output pass always runs and streams A unchanged, so latency does not depend on the data.

Decomposition:
- Shared package mmp_iddmm_pkg:
  - State enum: IDLE, SCAN, SDRAIN, DECIDE, OUT, ODRAIN, DONE.
  - Constants: word width 128, word count 32, address width 5.
- Sub-module mmp_iddmm_sub_dly: a RD_LAT-deep register delay line with asynchronous active-high reset, carrying {valid, last, addr} alongside the RAM read.

Test Plan (the first four use N=4, WD=8, RD_LAT=1):
- Less-than case: A={0x10,0,0,0}, M={0x20,0,0,0}, an=0 (words LSW first) -> borrow=1, sel_sub=0 -> res words A unchanged; comp_end at cycle 12 after start.
- Greater-than case: A={0x05,0x01,0,0}, M={0xFF,0,0,0}, an=0 -> res={0x06,0x00,0,0}; res_last with index 3.
- Top carry set: an=1, A={0,0,0,0}, M={1,0,0,0} -> res={0xFF,0xFF,0xFF,0xFF}.
- Equal operands: A=M={0xAA,0x55,0x12,0x34}, an=0 -> all-zero result.
- Held request: comp_req held high 5 cycles past comp_end -> no second start; a re-raised comp_req starts a new operation.
- Reset mid-operation: assert rst during OUT -> res_valid and comp_end go low immediately; the next request completes normally.
  - Repeat with MMP_SUB_SKIP_EN defined on the less-than case -> comp_end after 7 cycles, no res_valid.
